// File: rtl/e_mdu_pkg.sv
// Shared constants for the Execute-stage multiply/divide unit: op codes and default latencies.
// Imported by the unit, the controller and the hazard unit.
package e_mdu_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Execute-stage multiply/divide bus: operation request from the pipeline, HI/LO state back.
interface e_mdu_if;
  logic [3:0]  E_MDOp;
  logic        E_Start;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_Busy;
  logic [31:0] E_HI;
  logic [31:0] E_LO;
  logic [31:0] E_MDData;

  modport master (output E_MDOp, E_Start, E_A, E_B,
                  input  E_Busy, E_HI, E_LO, E_MDData);
  modport slave  (input  E_MDOp, E_Start, E_A, E_B,
                  output E_Busy, E_HI, E_LO, E_MDData);
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at Start and held in
// hi_n/lo_n; a latency counter models the fixed busy period and commits on its 1->0 edge.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic   clk,
  input logic   reset,
  e_mdu_if.slave md
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   hi, lo, hi_n, lo_n;
  logic          busy, accept_start;

  logic [63:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  logic [31:0] div_safe, quot_s, rem_s, quot_u, rem_u;
  logic [31:0] res_hi, res_lo;

  assign busy         = (cnt != '0);
  assign accept_start = md.E_Start && !busy && (is_mult_op(md.E_MDOp) || is_div_op(md.E_MDOp));

  assign a_sx   = {{32{md.E_A[31]}}, md.E_A};
  assign b_sx   = {{32{md.E_B[31]}}, md.E_B};
  assign a_zx   = {32'd0, md.E_A};
  assign b_zx   = {32'd0, md.E_B};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // A zero divisor never commits anything new, so substitute 1 to keep the dividers X-free.
  assign div_safe = (md.E_B == 32'd0) ? 32'd1 : md.E_B;
  assign quot_s   = $signed(md.E_A) / $signed(div_safe);
  assign rem_s    = $signed(md.E_A) % $signed(div_safe);
  assign quot_u   = md.E_A / div_safe;
  assign rem_u    = md.E_A % div_safe;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (md.E_MDOp)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV:   if (md.E_B != 32'd0) begin res_hi = rem_s; res_lo = quot_s; end
      MD_DIVU:  if (md.E_B != 32'd0) begin res_hi = rem_u; res_lo = quot_u; end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      hi_n <= '0;
      lo_n <= '0;
    end else if (accept_start) begin
      cnt  <= is_mult_op(md.E_MDOp) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      hi_n <= res_hi;
      lo_n <= res_lo;
    end else if (busy) begin
      // Ops arriving while busy are protocol violations and are dropped here.
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        hi <= hi_n;
        lo <= lo_n;
      end
    end else if (md.E_MDOp == MD_MTHI) begin
      hi <= md.E_A;
    end else if (md.E_MDOp == MD_MTLO) begin
      lo <= md.E_A;
    end
  end

  always_comb begin
    md.E_MDData = 32'd0;
    if (md.E_MDOp == MD_MFHI) md.E_MDData = hi;
    else if (md.E_MDOp == MD_MFLO) md.E_MDData = lo;
  end

  assign md.E_Busy = busy;
  assign md.E_HI   = hi;
  assign md.E_LO   = lo;

endmodule
